// File: rtl/rr_bus_arbiter3_if.sv
// Request/grant bundle between three bus sources and the round-robin arbiter.
// Latency: n/a (wires only). Backpressure: none; req is level-held by each source.
interface rr_bus_arbiter3_if #(
    parameter int CW = 4
);
    logic [2:0]    req;
    logic [2:0]    grant;
    logic [2:0]    sel;
    logic          busy;
    logic [CW-1:0] hold_cnt;

    modport master (input req, output grant, sel, busy, hold_cnt);
    modport slave  (output req, input grant, sel, busy, hold_cnt);
endinterface

// File: rtl/rr_bus_arbiter3.sv
// Round-robin arbiter for one shared 3-source bus; drives a registered one-hot grant and mux select.
// Latency: req sampled at edge t is reflected in grant/sel/busy/hold_cnt right after edge t.
// Backpressure: sources hold req until granted; a hold limit forces rotation when others wait.
module rr_bus_arbiter3 #(
    parameter int MAXHOLD = 8,
    parameter int CW      = 4
) (
    input  logic            clk,
    input  logic            rst,
    rr_bus_arbiter3_if.master bus
);
    typedef enum logic {IDLE, OWNED} state_t;

    localparam logic [CW-1:0] HOLD_SAT = '1;

    state_t     state;
    logic [1:0] last;

    logic [2:0] others;
    logic       owner_req;
    logic       preempt;
    logic [1:0] win;

    // First requester after 'from' in the order from+1, from+2, from (mod 3).
    function automatic logic [1:0] pick(input logic [1:0] from, input logic [2:0] r);
        logic [1:0] w;
        logic [1:0] idx;
        w = from;
        for (int k = 3; k >= 1; k--) begin
            idx = 2'((int'(from) + k) % 3);
            if (r[idx]) w = idx;
        end
        return w;
    endfunction

    // Masking the owner's bit makes one pick() cover grant-from-idle, release and preemption.
    always_comb begin
        others    = bus.req & ~bus.grant;
        owner_req = |(bus.req & bus.grant);
        preempt   = (MAXHOLD != 0) && (int'(bus.hold_cnt) >= MAXHOLD) && (|others);
        win       = pick(last, others);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            last         <= 2'd2;
            bus.grant    <= 3'b000;
            bus.sel      <= 3'b001;
            bus.busy     <= 1'b0;
            bus.hold_cnt <= '0;
        end else if (state == OWNED && owner_req && !preempt) begin
            if (bus.hold_cnt != HOLD_SAT) bus.hold_cnt <= bus.hold_cnt + 1'b1;
        end else if (|others) begin
            state        <= OWNED;
            last         <= win;
            bus.grant    <= 3'b001 << win;
            bus.sel      <= 3'b001 << win;
            bus.busy     <= 1'b1;
            bus.hold_cnt <= CW'(1);
        end else begin
            // sel keeps parking the bus on the last owner while idle
            state        <= IDLE;
            bus.grant    <= 3'b000;
            bus.busy     <= 1'b0;
            bus.hold_cnt <= '0;
        end
    end

    a_grant_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(bus.grant));
    a_sel_onehot    : assert property (@(posedge clk) disable iff (rst) $onehot(bus.sel));
    a_busy_grant    : assert property (@(posedge clk) disable iff (rst) bus.busy == (|bus.grant));
    a_grant_had_req : assert property (@(posedge clk) disable iff (rst)
                                       (bus.grant & ~$past(bus.req)) == 3'b000);
endmodule

// File: tb/tb_rr_bus_arbiter3.sv
// Bench for rr_bus_arbiter3: two instances (hold limit 8 and 0) share one req stimulus.
module tb_rr_bus_arbiter3;
    logic       clk;
    logic       rst;
    logic [2:0] req;
    logic [2:0] req_q;

    int n_cmp = 0;
    int n_err = 0;

    rr_bus_arbiter3_if #(.CW(4)) bus8 ();
    rr_bus_arbiter3_if #(.CW(4)) bus0 ();
    assign bus8.req = req;
    assign bus0.req = req;

    rr_bus_arbiter3 #(.MAXHOLD(8), .CW(4)) dut8 (.clk(clk), .rst(rst), .bus(bus8.master));
    rr_bus_arbiter3 #(.MAXHOLD(0), .CW(4)) dut0 (.clk(clk), .rst(rst), .bus(bus0.master));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: owner index (-1 = idle), last owner, hold count, parked select index.
    typedef struct packed { int own; int last; int hold; int selx; } mst_t;
    mst_t m[2];
    logic m_valid = 1'b0;
    localparam mst_t RST_ST = '{own: -1, last: 2, hold: 0, selx: 0};

    function automatic int first_from(input int from, input logic [2:0] r);
        for (int k = 1; k <= 3; k++) if (r[(from + k) % 3]) return (from + k) % 3;
        return -1;
    endfunction

    function automatic mst_t nxt(input mst_t s, input logic [2:0] r, input int mh);
        mst_t       n;
        int         w;
        logic [2:0] oth;
        n = s;
        if (s.own >= 0 && r[s.own]) begin
            oth = r;
            oth[s.own] = 1'b0;
            if (mh != 0 && s.hold >= mh && oth != 3'b000) begin
                w = first_from(s.own, oth);
                n.own = w; n.last = w; n.selx = w; n.hold = 1;
            end else begin
                n.hold = (s.hold < 15) ? s.hold + 1 : 15;
            end
        end else if (r != 3'b000) begin
            w = first_from(s.last, r);
            n.own = w; n.last = w; n.selx = w; n.hold = 1;
        end else begin
            n.own = -1; n.hold = 0;
        end
        return n;
    endfunction

    always @(posedge clk) begin
        req_q <= req;
        if (rst) m_valid <= 1'b1;
        for (int d = 0; d < 2; d++)
            m[d] <= rst ? RST_ST : nxt(m[d], req, (d == 0) ? 8 : 0);
    end

    int waitc[3] = '{0, 0, 0};

    // Every-cycle comparison of both instances against the model, plus the starvation bound.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("m8.grant", int'(bus8.grant), (m[0].own < 0) ? 0 : (1 << m[0].own));
            chk("m8.sel",   int'(bus8.sel),   1 << m[0].selx);
            chk("m8.busy",  int'(bus8.busy),  (m[0].own >= 0) ? 1 : 0);
            chk("m8.hold",  int'(bus8.hold_cnt), m[0].hold);
            chk("m0.grant", int'(bus0.grant), (m[1].own < 0) ? 0 : (1 << m[1].own));
            chk("m0.sel",   int'(bus0.sel),   1 << m[1].selx);
            chk("m0.busy",  int'(bus0.busy),  (m[1].own >= 0) ? 1 : 0);
            chk("m0.hold",  int'(bus0.hold_cnt), m[1].hold);
            for (int i = 0; i < 3; i++) begin
                if (waitc[i] > 18) chk("wait_bound", waitc[i], 18);
                waitc[i] <= (!rst && req_q[i] && !bus8.grant[i]) ? waitc[i] + 1 : 0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".grant8"}, int'(bus8.grant), 0);
        chk({tag, ".sel8"},   int'(bus8.sel),   1);
        chk({tag, ".busy8"},  int'(bus8.busy),  0);
        chk({tag, ".hold8"},  int'(bus8.hold_cnt), 0);
        chk({tag, ".grant0"}, int'(bus0.grant), 0);
        chk({tag, ".sel0"},   int'(bus0.sel),   1);
    endtask

    initial begin
        logic [2:0] r3;
        rst = 1'b1;
        req = 3'b001;
        tick(2);
        chk_reset("t1.reset");
        rst = 1'b0;

        // Single requester: one-cycle latency, counting hold.
        tick(1);
        chk("t1.grant", int'(bus8.grant), 1);
        chk("t1.busy",  int'(bus8.busy), 1);
        chk("t1.hold1", int'(bus8.hold_cnt), 1);
        tick(2);
        chk("t1.hold3", int'(bus8.hold_cnt), 3);
        chk("t1.sel",   int'(bus8.sel), 1);

        // Full rotation under hold limit 8; the unlimited instance never rotates.
        rst = 1'b1;
        req = 3'b111;
        tick(1);
        rst = 1'b0;
        for (int k = 1; k <= 33; k++) begin
            tick(1);
            chk("t2.grant8", int'(bus8.grant), 1 << (((k - 1) / 8) % 3));
            chk("t2.hold8",  int'(bus8.hold_cnt), ((k - 1) % 8) + 1);
            chk("t2.grant0", int'(bus0.grant), 1);
            chk("t2.hold0",  int'(bus0.hold_cnt), (k < 15) ? k : 15);
        end

        // Owner 1 releases with 0 and 2 pending: rotation from 1 picks 2.
        req = 3'b101;
        tick(1);
        chk("t3.grant8", int'(bus8.grant), 4);
        chk("t3.sel8",   int'(bus8.sel), 4);
        chk("t3.hold8",  int'(bus8.hold_cnt), 1);
        req = 3'b000;
        tick(1);
        chk("t3.idle8",  int'(bus8.grant), 0);
        chk("t3.busy8",  int'(bus8.busy), 0);
        chk("t3.park8",  int'(bus8.sel), 4);
        chk("t3.park0",  int'(bus0.sel), 1);

        // Solo owner saturates its hold count and is never preempted.
        req = 3'b010;
        tick(20);
        chk("t4.grant8", int'(bus8.grant), 2);
        chk("t4.sat8",   int'(bus8.hold_cnt), 15);
        chk("t4.sat0",   int'(bus0.hold_cnt), 15);
        req = 3'b000;
        tick(1);
        req = 3'b011;
        tick(12);
        chk("t4.nolimit.grant0", int'(bus0.grant), 1);
        chk("t4.nolimit.hold0",  int'(bus0.hold_cnt), 12);
        chk("t4.limit.grant8",   int'(bus8.grant), 2);
        chk("t4.limit.hold8",    int'(bus8.hold_cnt), 4);
        req = 3'b010;
        tick(1);
        chk("t4.drop.grant0", int'(bus0.grant), 2);
        chk("t4.drop.hold0",  int'(bus0.hold_cnt), 1);
        chk("t4.keep.hold8",  int'(bus8.hold_cnt), 5);

        // Reset while requester 2 owns the bus with hold 5.
        req = 3'b100;
        tick(5);
        chk("t5.pre.grant8", int'(bus8.grant), 4);
        chk("t5.pre.hold8",  int'(bus8.hold_cnt), 5);
        rst = 1'b1;
        req = 3'b111;
        tick(1);
        chk_reset("t5.reset");
        rst = 1'b0;
        tick(1);
        chk("t5.first.grant8", int'(bus8.grant), 1);
        chk("t5.first.grant0", int'(bus0.grant), 1);

        // Random toggling of request bits, checked every cycle by the model process.
        r3 = req;
        for (int c = 0; c < 10000; c++) begin
            for (int b = 0; b < 3; b++)
                if ($urandom_range(0, 7) == 0) r3[b] = ~r3[b];
            req = r3;
            tick(1);
        end
        req = 3'b000;
        tick(3);
        chk("t6.drain.grant8", int'(bus8.grant), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/rr_bus_arbiter3.md
Name: rr_bus_arbiter3

Overview:
Round-robin arbiter for one shared 3-source bus, built on the team's one-hot 3:1 mux.
- Three requesters compete for the bus.
- The block issues a registered one-hot grant and drives the mux select.
- The select is always a legal one-hot code, so the mux never falls into its X default.
- A hold limit bounds how long one requester keeps the bus while others wait.

Parameters:
MAXHOLD, 8, number of consecutive granted cycles before forced rotation when another requester is waiting; 0 disables preemption.
CW, 4, width of the hold counter; must satisfy 2^CW > MAXHOLD.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  reset; one clock, synchronous, active-high
req  input  3  request vector; bit i = requester i wants the bus
grant  output  3  registered one-hot grant; 000 = bus idle
sel  output  3  one-hot select to the shared mux; never 000, never multi-hot
busy  output  1  high when grant != 000
hold_cnt  output  CW  cycles the current owner has held grant, saturating

Behaviour:
- States: IDLE (grant=000) and OWNED (grant one-hot). All outputs registered; no combinational path from req to outputs.
- Reset values on a rst edge:
  - grant=000, sel=001, busy=0, hold_cnt=0.
  - Internal last-owner pointer = 2, so requester 0 has highest priority first.
  - rst overrides all other inputs, including mid-grant; the bus is released on that same edge.
- Priority order: search starts at (last+1) mod 3 and wraps, e.g. last=1 gives order 2,0,1.
- Latency: req seen at edge t gives grant at edge t (visible in the following cycle). One-cycle request-to-grant latency.
- IDLE -> OWNED: any req bit set. Grant the first requester in rotation order. Set last=winner, hold_cnt=1.
- OWNED, owner req still high:
  - If MAXHOLD!=0, hold_cnt==MAXHOLD, and another req bit is set: grant moves to the next requester in rotation order. The new owner's hold_cnt=1. No idle cycle.
  - Otherwise owner keeps grant and hold_cnt increments, saturating at 2^CW-1.
- OWNED, owner req low:
  - If other requests are pending, grant goes to the next in rotation order from the releasing owner on that edge (back-to-back handoff, hold_cnt=1).
  - If none are pending, go to IDLE: grant=000, hold_cnt=0.
- The owner dropping and re-raising req is a new request; it competes in rotation order with itself last.
- sel = grant in OWNED. In IDLE, sel holds the last owner's one-hot code (parks the bus on the last source). After reset it is 001.
- busy = OR of grant bits, registered with grant.
- Invariants, checked by assertions:
  - grant is 000 or one-hot.
  - sel is one-hot.
  - A bit of grant is set only if the matching req bit was high at the preceding edge.
  - With MAXHOLD>0, no requester waits more than 2*MAXHOLD+2 cycles while its req stays high.
- req bits of non-owners may change any cycle; only their value at the decision edge matters.

Test Plan:
1. Reset then req=001 held: grant=000 in the first cycle after reset, grant=001/busy=1 the next cycle. hold_cnt then counts 1,2,3...; sel=001 throughout.
2. Rotation: req=111 held, MAXHOLD=8. Grant sequence 001 (8 cycles), 010 (8 cycles), 100 (8 cycles), 001. Each handoff has no idle cycle and hold_cnt restarts at 1.
3. Release and handoff: owner 1 (grant=010) drops req while req=101. Next edge grant=100 (rotation from 1), sel=100. Then req=000 gives grant=000, busy=0, sel stays 100.
4. Solo owner never preempted: req=010 for 20 cycles with MAXHOLD=8. grant stays 010 and hold_cnt saturates at 15 (CW=4). With MAXHOLD=0 and req=011, owner 0 keeps grant=001 until it drops req.
5. Reset mid-operation: grant=100, hold_cnt=5, assert rst for one edge with req=111. Outputs return to grant=000, sel=001, busy=0, hold_cnt=0. After rst falls, the first grant goes to requester 0 (001).
6. Random req stimulus for 10k cycles with assertions on: grant is always 000 or one-hot, sel is always one-hot, and every continuously held req is granted within 18 cycles (MAXHOLD=8).
